// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: ALUOp encodings, opcodes, and the decoder control bundle.
// No logic; imported by pipeline registers and their benches.
// CTRL_NOP is the all-zero bundle loaded into bubbles.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ALUOP_LWSW  = 2'b00,
        ALUOP_BEQ   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ORI   = 2'b11
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_ADD = 6'h20;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       zero_extend;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_reg_field.sv
// Generic pipeline register field with clear (bubble) and enable (advance).
// Latency: 1 cycle.
// Backpressure: en=0 holds contents; clr overrides en and loads zero.
module pipe_reg_field #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, flush bubble and load-use hazard detect.
// Latency: 1 cycle id_* -> ex_*; hazard output is combinational from EX state + ID specifiers.
// Backpressure: stall holds all state, flush (priority) loads a bubble; ID_EX_PERF_CNT_EN adds bubble_cnt.
module id_ex_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic                  id_reg_dst,
    input  logic                  id_alu_src,
    input  logic                  id_mem_to_reg,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_zero_extend,
    input  logic [1:0]            id_alu_op,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm_ext,
    input  logic [5:0]            id_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  ex_valid,
    output logic                  ex_reg_dst,
    output logic                  ex_alu_src,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_zero_extend,
    output logic [1:0]            ex_alu_op,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm_ext,
    output logic [5:0]            ex_funct,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]           bubble_cnt,
`endif
    output logic                  ex_load_use_hazard
);

    localparam int CTRL_W = $bits(ctrl_t) + 1;
    localparam int DAT_W  = 4 * DATA_W + 6 + 3 * REG_ADDR_W;

    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DAT_W-1:0]  dat_q;
    logic              bubble;

    // An empty decode slot advancing into EX is the same bubble as a flush.
    assign bubble = flush | (~stall & ~id_valid);

    always_comb begin
        id_ctrl             = CTRL_NOP;
        id_ctrl.reg_dst     = id_reg_dst;
        id_ctrl.alu_src     = id_alu_src;
        id_ctrl.mem_to_reg  = id_mem_to_reg;
        id_ctrl.reg_write   = id_reg_write;
        id_ctrl.mem_read    = id_mem_read;
        id_ctrl.mem_write   = id_mem_write;
        id_ctrl.branch      = id_branch;
        id_ctrl.zero_extend = id_zero_extend;
        id_ctrl.alu_op      = id_alu_op;
    end

    pipe_reg_field #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .clr   (bubble),
        .d     ({id_valid, id_ctrl}),
        .q     (ctrl_q)
    );

    pipe_reg_field #(.WIDTH(DAT_W)) u_dat_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .clr   (bubble),
        .d     ({id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
                 id_funct, id_rs, id_rt, id_rd}),
        .q     (dat_q)
    );

    assign ex_valid = ctrl_q[CTRL_W-1];
    assign ex_ctrl  = ctrl_q[CTRL_W-2:0];

    assign ex_reg_dst     = ex_ctrl.reg_dst;
    assign ex_alu_src     = ex_ctrl.alu_src;
    assign ex_mem_to_reg  = ex_ctrl.mem_to_reg;
    assign ex_reg_write   = ex_ctrl.reg_write;
    assign ex_mem_read    = ex_ctrl.mem_read;
    assign ex_mem_write   = ex_ctrl.mem_write;
    assign ex_branch      = ex_ctrl.branch;
    assign ex_zero_extend = ex_ctrl.zero_extend;
    assign ex_alu_op      = ex_ctrl.alu_op;

    assign {ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
            ex_funct, ex_rs, ex_rt, ex_rd} = dat_q;

    // $zero as a load target never creates a dependency.
    assign ex_load_use_hazard = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                                ((ex_rt == id_rs) | (ex_rt == id_rt));

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (bubble) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register of the five-stage MIPS core. It captures the main decoder's control bundle and the decode-stage operands (register data, sign/zero-extended immediate, register specifiers, PC+4) and presents them to EX one cycle later. It supports stall (hold) and flush (bubble insert), and tracks a valid bit. It also raises the load-use hazard indication consumed by the IF/ID stall logic.

Parameters:
DATA_W, 32, width of datapath words (register data, immediate, PC+4)
REG_ADDR_W, 5, width of register specifiers

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold all contents this cycle
flush  input  1  load a bubble this cycle
id_valid  input  1  decode slot holds a real instruction
id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_zero_extend  input  1 each  decoder control bits
id_alu_op  input  2  decoder ALUOp
id_pc_plus4  input  DATA_W  PC+4 of decode instruction
id_rs_data, id_rt_data  input  DATA_W  register file read data
id_imm_ext  input  DATA_W  extended immediate
id_funct  input  6  instr[5:0]
id_rs, id_rt, id_rd  input  REG_ADDR_W  register specifiers
ex_valid  output  1  EX slot holds a real instruction
ex_* (one per id_* input above)  output  same width  registered copies
ex_load_use_hazard  output  1  EX load targets a register read by the instruction in ID

Behaviour:
- Reset (rst_n low, async): every ex_* output and ex_valid = 0; hazard output therefore 0. Release is synchronous to clk.
- Per rising edge, priority: flush > stall > load.
- flush=1: ex_valid=0, all control outputs=0, all data/specifier outputs=0 (a clean bubble). Applies even if stall=1.
- stall=1, flush=0: all registers hold; ex_valid unchanged.
- Load (stall=0, flush=0): if id_valid=1, capture all id_* and set ex_valid=1. If id_valid=0, load a bubble identical to flush.
- Latency: exactly 1 cycle from the id_* inputs to the ex_* outputs; no combinational path from id_* control/data inputs to ex_* outputs.
- ex_load_use_hazard = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)). This is a combinational function of the registered state plus the ID specifiers; it uses no stall or flush inputs.
- Bubble invariant: ex_valid=0 implies ex_reg_write = ex_mem_write = ex_mem_read = ex_branch = 0.
- Multiple consecutive stall cycles hold indefinitely. Asserting reset mid-stall clears the register immediately.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds output bubble_cnt [31:0]. It resets to 0 and increments (wrapping at 2^32-1 -> 0) on each edge where a bubble is loaded (flush=1, or stall=0 with id_valid=0). It does not increment on stall-hold cycles.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pipe_pkg: ALUOp encodings (LW/SW=00, BEQ=01, RTYPE=10, ORI=11), opcode constants, a packed typedef ctrl_t (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, zero_extend, alu_op), and CTRL_NOP = all zeros.
- Sub-module pipe_reg_field: a generic WIDTH-parameterised register with async active-low reset, en (=!stall), clr (=bubble) and clr priority over en. It is instantiated once for the control bundle plus valid and once for the data fields.

Test Plan:
- Reset: drive random id_*, assert rst_n=0 mid-cycle -> all ex_* = 0 immediately, ex_valid=0.
- Normal load: lw (mem_read=1, reg_write=1, alu_src=1, mem_to_reg=1, alu_op=00), rs_data=32'h10, imm=32'h4, rt=5 -> next edge ex_* match, ex_valid=1.
- Stall: load add, then stall=1 for 3 cycles while id_* changes -> ex_* stay equal to add for all 3 cycles, then the new instruction is loaded on release.
- Flush+stall together: stall=1, flush=1 with valid ori in ID -> ex_valid=0, all control 0.
- Load-use: EX holds lw rt=8, ID has rs=8 -> ex_load_use_hazard=1. With rt=0 -> 0. With ex_valid=0 -> 0. With ID rt=8 and rs=3 -> 1.
- With ID_EX_PERF_CNT_EN: 2 flushes, 1 id_valid=0 load and 4 stall cycles -> bubble_cnt=3. Preload the counter to 32'hFFFFFFFF, then one bubble -> 0.
